// File: rtl/dmem_responder.sv
// dmem_responder: zero-wait data-memory responder (word RAM + MMIO timer/GPIO/store counter); DMEM_TIMER_IRQ_EN adds CTRL and irq_o
module dmem_responder #(
  parameter int RAM_AW = 10,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              bus_err_o
`ifdef DMEM_TIMER_IRQ_EN
  ,
  output logic              irq_o
`endif
);
`ifdef DMEM_TIMER_IRQ_EN
  localparam logic [5:0] MMIO_N = 6'd6;
`else
  localparam logic [5:0] MMIO_N = 6'd5;
`endif
  logic [31:0] ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] idx;
  logic [5:0] off_w;
  logic ld, st, is_ram, is_mmio, mapped, wr_mmio, ram_we, unused_addr;
  logic [31:0] cycle_q, cycle_d, cmp_q, cmp_d, stcnt_q, stcnt_d, mmio_rd, gpio_rd;
  logic match_q, match_d, bus_err_q, bus_err_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
`ifdef DMEM_TIMER_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;
`endif
  assign idx         = data_addr_i[RAM_AW+1:2];
  assign off_w       = data_addr_i[7:2];
  assign unused_addr = ^data_addr_i;
  assign ld          = data_ce_i & ~data_we_i;
  assign st          = data_ce_i & data_we_i;
  assign is_ram      = data_addr_i[31:28] == 4'h0;
  assign is_mmio     = data_addr_i[31:28] == 4'h1;
  assign mapped      = is_ram | (is_mmio & (off_w < MMIO_N));
  assign wr_mmio     = st & is_mmio;
  // reset is folded into the write enable so a store racing reset never lands in RAM
  assign ram_we      = st & is_ram & rst_n;
  assign gpio_o      = gpio_q;
  assign bus_err_o   = bus_err_q;
`ifdef DMEM_TIMER_IRQ_EN
  assign irq_o       = irq_q;
`endif
  // MMIO read mux and combinational load path
  always_comb begin
    gpio_rd = '0;
    gpio_rd[GPIO_W-1:0] = gpio_q;
    case (off_w)
      6'd0:    mmio_rd = cycle_q;
      6'd1:    mmio_rd = cmp_q;
      6'd2:    mmio_rd = {31'b0, match_q};
      6'd3:    mmio_rd = gpio_rd;
      6'd4:    mmio_rd = stcnt_q;
`ifdef DMEM_TIMER_IRQ_EN
      6'd5:    mmio_rd = {31'b0, ie_q};
`endif
      default: mmio_rd = '0;
    endcase
    data_o = !ld ? '0 : is_ram ? ram_q[idx] : is_mmio ? mmio_rd : '0;
  end
  // register next-state: match set has priority over the RW1C clear
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    cmp_d     = (wr_mmio && off_w == 6'd1) ? data_i : cmp_q;
    match_d   = (cycle_q == cmp_q) | (match_q & ~(wr_mmio && off_w == 6'd2 && data_i[0]));
    gpio_d    = (wr_mmio && off_w == 6'd3) ? data_i[GPIO_W-1:0] : gpio_q;
    stcnt_d   = (st && is_ram) ? stcnt_q + 32'd1 : stcnt_q;
    bus_err_d = data_ce_i & ~mapped;
`ifdef DMEM_TIMER_IRQ_EN
    ie_d      = (wr_mmio && off_w == 6'd5) ? data_i[0] : ie_q;
    irq_d     = match_q & ie_q;
`endif
  end
  // register block with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      cmp_q     <= '1;
      match_q   <= 1'b0;
      gpio_q    <= '0;
      stcnt_q   <= '0;
      bus_err_q <= 1'b0;
`ifdef DMEM_TIMER_IRQ_EN
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      cycle_q   <= cycle_d;
      cmp_q     <= cmp_d;
      match_q   <= match_d;
      gpio_q    <= gpio_d;
      stcnt_q   <= stcnt_d;
      bus_err_q <= bus_err_d;
`ifdef DMEM_TIMER_IRQ_EN
      ie_q      <= ie_d;
      irq_q     <= irq_d;
`endif
    end
  end
  // RAM write port; contents are never reset
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[idx] <= data_i;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder
module tb_dmem_responder;
  logic clk, rst_n, ce, we;
  logic [31:0] addr, wdata, rdata;
  logic [7:0] gpio;
  logic berr;
  logic [31:0] mcyc, e, c;
  logic [31:0] exp_q[$];
  int n_chk, n_pass;
`ifdef DMEM_TIMER_IRQ_EN
  logic irq;
`endif

  dmem_responder #(.RAM_AW(10), .GPIO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_ce_i(ce), .data_we_i(we),
    .data_addr_i(addr), .data_i(wdata), .data_o(rdata),
    .gpio_o(gpio), .bus_err_o(berr)
`ifdef DMEM_TIMER_IRQ_EN
    , .irq_o(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference CYCLE value: cleared by reset, +1 per clock
  always @(posedge clk or negedge rst_n)
    if (!rst_n) mcyc <= 32'd0;
    else mcyc <= mcyc + 32'd1;

  task automatic drv(input logic c_, input logic w_, input logic [31:0] a_, input logic [31:0] d_);
    @(negedge clk);
    ce = c_; we = w_; addr = a_; wdata = d_;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    drv(1, 0, 32'h1000_0004, 0);
    exp_q.push_back(32'hFFFF_FFFF);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL reset_cmp got %h exp %h", rdata, e); else n_pass++;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if ({24'b0, gpio} !== e) $display("FAIL reset_gpio got %h exp %h", gpio, e); else n_pass++;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if ({31'b0, berr} !== e) $display("FAIL reset_berr got %h exp %h", berr, e); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; ce = 1'b0;
  endtask

  task automatic test_ram();
    drv(1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    exp_q.push_back(32'h0);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL store_data_o got %h exp %h", rdata, e); else n_pass++;
    drv(1, 0, 32'h0000_0010, 0);
    exp_q.push_back(32'hDEAD_BEEF);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL ram_load got %h exp %h", rdata, e); else n_pass++;
    drv(1, 0, 32'h1000_0010, 0);
    exp_q.push_back(32'd1);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL stcnt_1 got %h exp %h", rdata, e); else n_pass++;
  endtask

  task automatic test_alias();
    drv(1, 1, 32'h0000_1010, 32'h1234_5678);
    drv(1, 0, 32'h0000_0010, 0);
    exp_q.push_back(32'h1234_5678);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL alias_load got %h exp %h", rdata, e); else n_pass++;
    drv(0, 0, 32'h0000_0010, 0);
    exp_q.push_back(32'h0);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL ce0_load got %h exp %h", rdata, e); else n_pass++;
    drv(1, 0, 32'h1000_0010, 0);
    exp_q.push_back(32'd2);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL stcnt_2 got %h exp %h", rdata, e); else n_pass++;
  endtask

  task automatic test_timer();
    apply_reset();
    repeat (4) drv(0, 0, 0, 0);
    drv(1, 1, 32'h1000_0004, 32'd20);
    drv(1, 0, 32'h1000_0000, 0);
    exp_q.push_back(mcyc);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL cycle_read got %h exp %h", rdata, e); else n_pass++;
    for (int i = 0; i < 22; i++) begin
      drv(1, 0, 32'h1000_0008, 0);
      exp_q.push_back((mcyc > 32'd20) ? 32'd1 : 32'd0);
      #1 e = exp_q.pop_front(); n_chk++;
      if (rdata !== e) $display("FAIL status_poll cyc %0d got %h exp %h", mcyc, rdata, e); else n_pass++;
    end
    drv(1, 1, 32'h1000_0008, 32'd1);
    drv(1, 0, 32'h1000_0008, 0);
    exp_q.push_back(32'd0);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL status_clear got %h exp %h", rdata, e); else n_pass++;
    c = mcyc + 32'd3;
    drv(1, 1, 32'h1000_0004, c);
    drv(1, 0, 32'h1000_0008, 0);
    exp_q.push_back(32'd0);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL status_pre_match got %h exp %h", rdata, e); else n_pass++;
    drv(1, 1, 32'h1000_0008, 32'd1);
    drv(1, 0, 32'h1000_0008, 0);
    exp_q.push_back(32'd1);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL set_wins got %h exp %h", rdata, e); else n_pass++;
  endtask

  task automatic test_gpio_reset();
    drv(1, 1, 32'h1000_000C, 32'h0000_01A5);
    drv(1, 0, 32'h1000_000C, 0);
    exp_q.push_back(32'h0000_00A5);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL gpio_read got %h exp %h", rdata, e); else n_pass++;
    exp_q.push_back(32'h0000_00A5);
    e = exp_q.pop_front(); n_chk++;
    if ({24'b0, gpio} !== e) $display("FAIL gpio_out got %h exp %h", gpio, e); else n_pass++;
    #2 rst_n = 1'b0; addr = 32'h1000_0000;
    exp_q.push_back(32'h0);
    #1 e = exp_q.pop_front(); n_chk++;
    if ({24'b0, gpio} !== e) $display("FAIL gpio_async_rst got %h exp %h", gpio, e); else n_pass++;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL cycle_in_rst got %h exp %h", rdata, e); else n_pass++;
    drv(1, 1, 32'h1000_000C, 32'h0000_00FF);
    drv(1, 1, 32'h0000_0010, 32'h0000_0BAD);
    @(negedge clk);
    rst_n = 1'b1; ce = 1'b1; we = 1'b0; addr = 32'h0000_0010;
    exp_q.push_back(32'h1234_5678);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL ram_wr_in_rst got %h exp %h", rdata, e); else n_pass++;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if ({24'b0, gpio} !== e) $display("FAIL gpio_wr_in_rst got %h exp %h", gpio, e); else n_pass++;
  endtask

  task automatic test_bus_err();
    apply_reset();
    drv(1, 1, 32'h0000_0040, 32'h55AA_55AA);
    drv(1, 0, 32'h2000_0000, 0);
    exp_q.push_back(32'h0);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL unmapped_load got %h exp %h", rdata, e); else n_pass++;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); n_chk++;
    if ({31'b0, berr} !== e) $display("FAIL berr_after_good got %h exp %h", berr, e); else n_pass++;
    drv(1, 1, 32'h1000_0040, 32'h0000_0077);
    exp_q.push_back(32'h1);
    #1 e = exp_q.pop_front(); n_chk++;
    if ({31'b0, berr} !== e) $display("FAIL berr_first got %h exp %h", berr, e); else n_pass++;
    drv(0, 0, 32'h0, 0);
    exp_q.push_back(32'h1);
    #1 e = exp_q.pop_front(); n_chk++;
    if ({31'b0, berr} !== e) $display("FAIL berr_second got %h exp %h", berr, e); else n_pass++;
    drv(1, 0, 32'h1000_0010, 0);
    exp_q.push_back(32'h0);
    #1 e = exp_q.pop_front(); n_chk++;
    if ({31'b0, berr} !== e) $display("FAIL berr_drop got %h exp %h", berr, e); else n_pass++;
    exp_q.push_back(32'd1);
    e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL stcnt_unmapped got %h exp %h", rdata, e); else n_pass++;
    drv(1, 0, 32'h0000_0040, 0);
    exp_q.push_back(32'h55AA_55AA);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL ram_unchanged got %h exp %h", rdata, e); else n_pass++;
`ifndef DMEM_TIMER_IRQ_EN
    drv(1, 0, 32'h1000_0014, 0);
    exp_q.push_back(32'h0);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL off14_read got %h exp %h", rdata, e); else n_pass++;
    drv(0, 0, 32'h0, 0);
    exp_q.push_back(32'h1);
    #1 e = exp_q.pop_front(); n_chk++;
    if ({31'b0, berr} !== e) $display("FAIL off14_berr got %h exp %h", berr, e); else n_pass++;
`endif
  endtask

`ifdef DMEM_TIMER_IRQ_EN
  task automatic test_irq();
    apply_reset();
    drv(1, 1, 32'h1000_0014, 32'd1);
    drv(1, 0, 32'h1000_0014, 0);
    exp_q.push_back(32'd1);
    #1 e = exp_q.pop_front(); n_chk++;
    if (rdata !== e) $display("FAIL ctrl_read got %h exp %h", rdata, e); else n_pass++;
    c = mcyc + 32'd6;
    drv(1, 1, 32'h1000_0004, c);
    for (int i = 0; i < 12; i++) begin
      drv(0, 0, 32'h0, 0);
      exp_q.push_back((mcyc >= c + 32'd2) ? 32'd1 : 32'd0);
      #1 e = exp_q.pop_front(); n_chk++;
      if ({31'b0, irq} !== e) $display("FAIL irq_rise cyc %0d got %h exp %h", mcyc, irq, e); else n_pass++;
    end
    drv(1, 1, 32'h1000_0008, 32'd1);
    drv(0, 0, 32'h0, 0);
    drv(0, 0, 32'h0, 0);
    exp_q.push_back(32'd0);
    #1 e = exp_q.pop_front(); n_chk++;
    if ({31'b0, irq} !== e) $display("FAIL irq_fall got %h exp %h", irq, e); else n_pass++;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_ram();
    test_alias();
    test_timer();
    test_gpio_reset();
    test_bus_err();
`ifdef DMEM_TIMER_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
